// File: rtl/dcache_pass_queue_if.sv
// AXI3 read and write master buses for the uncached dcache pass queue.
// Single-beat traffic only; ID fields are 4 bits wide.
interface axi3_rd_bus #(parameter int DATA_WIDTH = 32);
  logic [3:0]            arid;
  logic [31:0]           araddr;
  logic [3:0]            arlen;
  logic [2:0]            arsize;
  logic [1:0]            arburst;
  logic [1:0]            arlock;
  logic [3:0]            arcache;
  logic [2:0]            arprot;
  logic                  arvalid;
  logic                  arready;
  logic [3:0]            rid;
  logic [DATA_WIDTH-1:0] rdata;
  logic [1:0]            rresp;
  logic                  rlast;
  logic                  rvalid;
  logic                  rready;

  modport master (
    output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready
  );
endinterface

interface axi3_wr_bus #(parameter int DATA_WIDTH = 32);
  logic [3:0]              awid;
  logic [31:0]             awaddr;
  logic [3:0]              awlen;
  logic [2:0]              awsize;
  logic [1:0]              awburst;
  logic [1:0]              awlock;
  logic [3:0]              awcache;
  logic [2:0]              awprot;
  logic                    awvalid;
  logic                    awready;
  logic [3:0]              wid;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wlast;
  logic                    wvalid;
  logic                    wready;
  logic [3:0]              bid;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;

  modport master (
    output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
    input  awready,
    output wid, wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready
  );
endinterface

// File: rtl/dcache_pass_queue.sv
// In-order uncached load/store queue draining to AXI3 as single-beat transactions,
// with posted stores and a load response FIFO.
//
// state  | meaning
// R_IDLE | no load in flight; stores at the head may issue
// R_AR   | load address presented, waiting for arready
// R_WAIT | load accepted, waiting for the read data beat
module dcache_pass_queue #(
  parameter int DATA_WIDTH         = 32,
  parameter int ARID               = 2,
  parameter int AWID               = 2,
  parameter int DATA_DEPTH         = 8,
  parameter int RESP_DEPTH         = 4,
  parameter int MAX_WR_OUTSTANDING = 4,
  localparam int BE_W    = DATA_WIDTH / 8,
  localparam int OFS_W   = $clog2(BE_W),
  localparam int LABEL_W = 32 - OFS_W,
  localparam int LINE_W  = 1 + BE_W + LABEL_W + DATA_WIDTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [LINE_W-1:0] pline,
  input  logic              push,
  output logic              full,
  output logic [LINE_W-1:0] rline,
  output logic              rvalid,
  input  logic              rpop,
  output logic              idle,
  output logic              err,
  axi3_rd_bus.master        axi3_rd_if,
  axi3_wr_bus.master        axi3_wr_if
);

  localparam int QP_W = $clog2(DATA_DEPTH);
  localparam int RP_W = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
  localparam logic [QP_W:0] Q_FULL   = (QP_W + 1)'(DATA_DEPTH);
  localparam logic [RP_W:0] R_FULL   = (RP_W + 1)'(RESP_DEPTH);
  localparam logic [3:0]    WR_MAX   = 4'(MAX_WR_OUTSTANDING);
  localparam logic [RP_W-1:0] R_LAST = RP_W'(RESP_DEPTH - 1);

  typedef enum logic [1:0] {R_IDLE, R_AR, R_WAIT} r_state_t;

  logic [LINE_W-1:0] q_mem [DATA_DEPTH];
  logic [QP_W-1:0]   q_rd, q_wr;
  logic [QP_W:0]     q_cnt;
  logic              q_push, q_pop, q_nonempty;

  logic [LINE_W-1:0] r_mem [RESP_DEPTH];
  logic [RP_W-1:0]   r_rd, r_wr;
  logic [RP_W:0]     r_cnt;
  logic              resp_wr, resp_rd;

  logic [LINE_W-1:0]     head;
  logic                  head_ld;
  logic [BE_W-1:0]       head_wbe;
  logic [LABEL_W-1:0]    head_label;
  logic [DATA_WIDTH-1:0] head_data;
  logic [31:0]           head_addr;

  r_state_t           r_state;
  logic               arvalid_q, rready_q, bready_q;
  logic [BE_W-1:0]    ld_wbe;
  logic [LABEL_W-1:0] ld_label;
  logic               ld_start, ld_pop, r_hs;

  logic [3:0] wr_out;
  logic       aw_done, w_done;
  logic       st_issue, aw_hs, w_hs, st_pop, b_hs;

  function automatic logic [RP_W-1:0] r_next(input logic [RP_W-1:0] p);
    return (p == R_LAST) ? '0 : p + 1'b1;
  endfunction

  assign head       = q_mem[q_rd];
  assign head_ld    = head[LINE_W-1];
  assign head_wbe   = head[LINE_W-2 -: BE_W];
  assign head_label = head[DATA_WIDTH +: LABEL_W];
  assign head_data  = head[DATA_WIDTH-1:0];
  assign head_addr  = 32'(head_label) << OFS_W;

  assign q_nonempty = (q_cnt != '0);
  assign full       = (q_cnt == Q_FULL);
  assign q_push     = push && !full;

  // A store may only start while no load owns the bus; once half-issued, neither
  // condition can change until it completes, so valids stay asserted.
  assign st_issue = q_nonempty && !head_ld && (wr_out < WR_MAX) && (r_state == R_IDLE);
  assign aw_hs    = st_issue && !aw_done && axi3_wr_if.awready;
  assign w_hs     = st_issue && !w_done && axi3_wr_if.wready;
  assign st_pop   = st_issue && (aw_done || aw_hs) && (w_done || w_hs);
  assign b_hs     = axi3_wr_if.bvalid && bready_q;

  assign ld_start = (r_state == R_IDLE) && q_nonempty && head_ld && (wr_out == '0) &&
                    !aw_done && !w_done && (r_cnt < R_FULL);
  assign ld_pop   = arvalid_q && axi3_rd_if.arready;
  assign r_hs     = rready_q && axi3_rd_if.rvalid;
  assign resp_wr  = r_hs && axi3_rd_if.rlast;
  assign resp_rd  = rpop && rvalid;

  assign q_pop = st_pop || ld_pop;

  assign rvalid = (r_cnt != '0);
  assign rline  = rvalid ? r_mem[r_rd] : '0;
  assign idle   = !q_nonempty && (r_state == R_IDLE) && (wr_out == '0);

  assign axi3_rd_if.arid    = 4'(ARID);
  assign axi3_rd_if.araddr  = head_addr;
  assign axi3_rd_if.arlen   = 4'd0;
  assign axi3_rd_if.arsize  = 3'(OFS_W);
  assign axi3_rd_if.arburst = 2'b01;
  assign axi3_rd_if.arlock  = 2'b00;
  assign axi3_rd_if.arcache = 4'd0;
  assign axi3_rd_if.arprot  = 3'd0;
  assign axi3_rd_if.arvalid = arvalid_q;
  assign axi3_rd_if.rready  = rready_q;

  assign axi3_wr_if.awid    = 4'(AWID);
  assign axi3_wr_if.awaddr  = head_addr;
  assign axi3_wr_if.awlen   = 4'd0;
  assign axi3_wr_if.awsize  = 3'(OFS_W);
  assign axi3_wr_if.awburst = 2'b01;
  assign axi3_wr_if.awlock  = 2'b00;
  assign axi3_wr_if.awcache = 4'd0;
  assign axi3_wr_if.awprot  = 3'd0;
  assign axi3_wr_if.awvalid = st_issue && !aw_done;
  assign axi3_wr_if.wid     = 4'(AWID);
  assign axi3_wr_if.wdata   = head_data;
  assign axi3_wr_if.wstrb   = head_wbe;
  assign axi3_wr_if.wlast   = 1'b1;
  assign axi3_wr_if.wvalid  = st_issue && !w_done;
  assign axi3_wr_if.bready  = bready_q;

  always_ff @(posedge clk) begin
    if (q_push) q_mem[q_wr] <= pline;
    if (resp_wr) r_mem[r_wr] <= {1'b1, ld_wbe, ld_label, axi3_rd_if.rdata};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q_rd      <= '0;
      q_wr      <= '0;
      q_cnt     <= '0;
      r_rd      <= '0;
      r_wr      <= '0;
      r_cnt     <= '0;
      wr_out    <= '0;
      aw_done   <= 1'b0;
      w_done    <= 1'b0;
      bready_q  <= 1'b0;
      r_state   <= R_IDLE;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      ld_wbe    <= '0;
      ld_label  <= '0;
      err       <= 1'b0;
    end else begin
      bready_q <= 1'b1;

      if (q_push) q_wr <= q_wr + 1'b1;
      if (q_pop) q_rd <= q_rd + 1'b1;
      if (q_push && !q_pop) q_cnt <= q_cnt + 1'b1;
      else if (!q_push && q_pop) q_cnt <= q_cnt - 1'b1;

      if (resp_wr) r_wr <= r_next(r_wr);
      if (resp_rd) r_rd <= r_next(r_rd);
      if (resp_wr && !resp_rd) r_cnt <= r_cnt + 1'b1;
      else if (!resp_wr && resp_rd) r_cnt <= r_cnt - 1'b1;

      if (st_pop) begin
        aw_done <= 1'b0;
        w_done  <= 1'b0;
      end else begin
        if (aw_hs) aw_done <= 1'b1;
        if (w_hs) w_done <= 1'b1;
      end

      if (st_pop && !b_hs) wr_out <= wr_out + 1'b1;
      else if (!st_pop && b_hs) wr_out <= wr_out - 1'b1;

      if ((b_hs && (axi3_wr_if.bresp != 2'b00 || axi3_wr_if.bid != 4'(AWID))) ||
          (r_hs && axi3_rd_if.rresp != 2'b00))
        err <= 1'b1;

      case (r_state)
        R_IDLE: begin
          if (ld_start) begin
            r_state   <= R_AR;
            arvalid_q <= 1'b1;
          end
        end
        R_AR: begin
          if (axi3_rd_if.arready) begin
            r_state   <= R_WAIT;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            ld_wbe    <= head_wbe;
            ld_label  <= head_label;
          end
        end
        R_WAIT: begin
          if (resp_wr) begin
            r_state  <= R_IDLE;
            rready_q <= 1'b0;
          end
        end
        default: begin
          r_state   <= R_IDLE;
          arvalid_q <= 1'b0;
          rready_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule
